// File: rtl/vector_store_unit.sv
// Vector store engine: walks a vector register beat by beat, waits out pending lanes,
// writes each beat to its LSQ-supplied memory row and signals completion by tag.
// Optional per-element mask (with beat skipping) is enabled by defining STORE_MASK_EN.
module vector_store_unit #(
    parameter int unsigned LANES  = 8,
    parameter int unsigned BEATS  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned TAG_W  = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [TAG_W-1:0]               req_tag,
    input  logic [4:0]                     req_vreg,
    input  logic [BEATS*ADDR_W-1:0]        req_lsq_addr,
`ifdef STORE_MASK_EN
    input  logic [LANES*BEATS-1:0]         req_mask,
`endif
    output logic                           vrf_rd_en,
    output logic [4:0]                     vrf_rd_reg,
    output logic [1:0]                     vrf_rd_beat,
    input  logic [LANES*(DATA_W+1)-1:0]    vrf_rd_data,
    output logic                           mem_we,
    output logic [ADDR_W-1:0]              mem_row,
    output logic [LANES*DATA_W-1:0]        mem_wdata,
    output logic [LANES-1:0]               mem_lane_en,
    output logic                           done_valid,
    output logic [TAG_W-1:0]               done_tag,
    output logic                           busy
);

    localparam int unsigned LANE_W = DATA_W + 1;
    localparam int unsigned MASK_W = LANES * BEATS;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]               state_q, state_d;
    logic [TAG_W-1:0]         tag_q, tag_d;
    logic [4:0]               vreg_q, vreg_d;
    logic [BEATS*ADDR_W-1:0]  addr_q, addr_d;
    logic [MASK_W-1:0]        mask_q, mask_d;
    logic [1:0]               beat_q, beat_d;
    logic [ADDR_W-1:0]        row_q, row_d;
    logic [LANES*DATA_W-1:0]  wdata_q, wdata_d;
    logic [LANES-1:0]         lane_en_q, lane_en_d;
    logic                     ready_q, busy_q, rd_en_q, we_q, done_q;

    logic [MASK_W-1:0]        req_mask_w;
    logic [LANES-1:0]         beat_en_c;
    logic                     pending_c;
    logic [2:0]               nxt_c;

`ifdef STORE_MASK_EN
    assign req_mask_w = req_mask;
`else
    assign req_mask_w = '1;
`endif

    assign beat_en_c = mask_q[beat_q*LANES +: LANES];

    // Lowest beat at or above start with any enabled lane: {found, beat}.
    function automatic logic [2:0] next_beat(input logic [MASK_W-1:0] m, input int start);
        logic [2:0] r;
        r = '0;
        for (int b = int'(BEATS) - 1; b >= 0; b--) begin
            if (b >= start && (|m[b*LANES +: LANES])) begin
                r = {1'b1, 2'(b)};
            end
        end
        return r;
    endfunction

    always_comb begin
        state_d   = state_q;
        tag_d     = tag_q;
        vreg_d    = vreg_q;
        addr_d    = addr_q;
        mask_d    = mask_q;
        beat_d    = beat_q;
        row_d     = row_q;
        wdata_d   = wdata_q;
        lane_en_d = lane_en_q;
        pending_c = 1'b0;
        nxt_c     = '0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    tag_d   = req_tag;
                    vreg_d  = req_vreg;
                    addr_d  = req_lsq_addr;
                    mask_d  = req_mask_w;
                    nxt_c   = next_beat(req_mask_w, 0);
                    beat_d  = nxt_c[1:0];
                    state_d = nxt_c[2] ? S_READ : S_DONE;
                end
            end
            S_READ: state_d = S_CHECK;
            S_CHECK: begin
                for (int l = 0; l < int'(LANES); l++) begin
                    if (beat_en_c[l] && vrf_rd_data[l*LANE_W + DATA_W]) begin
                        pending_c = 1'b1;
                    end
                end
                if (pending_c) begin
                    state_d = S_READ;
                end else begin
                    row_d     = addr_q[beat_q*ADDR_W +: ADDR_W];
                    lane_en_d = beat_en_c;
                    for (int l = 0; l < int'(LANES); l++) begin
                        wdata_d[l*DATA_W +: DATA_W] = vrf_rd_data[l*LANE_W +: DATA_W];
                    end
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                nxt_c = next_beat(mask_q, int'(beat_q) + 1);
                if (nxt_c[2]) begin
                    beat_d  = nxt_c[1:0];
                    state_d = S_READ;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            tag_q     <= '0;
            vreg_q    <= '0;
            addr_q    <= '0;
            mask_q    <= '0;
            beat_q    <= '0;
            row_q     <= '0;
            wdata_q   <= '0;
            lane_en_q <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            we_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tag_q     <= tag_d;
            vreg_q    <= vreg_d;
            addr_q    <= addr_d;
            mask_q    <= mask_d;
            beat_q    <= beat_d;
            row_q     <= row_d;
            wdata_q   <= wdata_d;
            lane_en_q <= lane_en_d;
            ready_q   <= (state_d == S_IDLE);
            busy_q    <= (state_d != S_IDLE);
            rd_en_q   <= (state_d == S_READ);
            we_q      <= (state_d == S_WRITE);
            done_q    <= (state_d == S_DONE);
        end
    end

    assign req_ready   = ready_q;
    assign busy        = busy_q;
    assign vrf_rd_en   = rd_en_q;
    assign vrf_rd_reg  = vreg_q;
    assign vrf_rd_beat = beat_q;
    assign mem_we      = we_q;
    assign mem_row     = row_q;
    assign mem_wdata   = wdata_q;
    assign mem_lane_en = lane_en_q;
    assign done_valid  = done_q;
    assign done_tag    = tag_q;

endmodule

// File: tb/tb_vector_store_unit.sv
// Self-checking bench for vector_store_unit: VRF/memory models plus a cycle-level
// expectation model built from beat costs; mask cases run when STORE_MASK_EN is defined.
module tb_vector_store_unit;

    localparam int LANES  = 8;
    localparam int DATA_W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [3:0]   req_tag = '0;
    logic [4:0]   req_vreg = '0;
    logic [31:0]  req_lsq_addr = '0;
`ifdef STORE_MASK_EN
    logic [31:0]  req_mask = '0;
`endif
    logic         vrf_rd_en;
    logic [4:0]   vrf_rd_reg;
    logic [1:0]   vrf_rd_beat;
    logic [LANES*(DATA_W+1)-1:0] vrf_rd_data = '0;
    logic         mem_we;
    logic [7:0]   mem_row;
    logic [LANES*DATA_W-1:0] mem_wdata;
    logic [7:0]   mem_lane_en;
    logic         done_valid;
    logic [3:0]   done_tag;
    logic         busy;

    vector_store_unit dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag),
        .req_vreg(req_vreg), .req_lsq_addr(req_lsq_addr),
`ifdef STORE_MASK_EN
        .req_mask(req_mask),
`endif
        .vrf_rd_en(vrf_rd_en), .vrf_rd_reg(vrf_rd_reg), .vrf_rd_beat(vrf_rd_beat),
        .vrf_rd_data(vrf_rd_data),
        .mem_we(mem_we), .mem_row(mem_row), .mem_wdata(mem_wdata), .mem_lane_en(mem_lane_en),
        .done_valid(done_valid), .done_tag(done_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; logic [7:0] row; logic [7:0] len; } wr_t;
    typedef struct { int cyc; logic [3:0] tag; } dn_t;
    typedef struct { int n; int wrel[4]; logic [7:0] row[4]; logic [7:0] len[4]; int drel; } exp_t;

    wr_t wq[$];
    dn_t dq[$];
    int  aq[$];

    logic [31:0] vdata [32][32];
    int          rdcnt [32][32] = '{default: 0};
    int          pend_base [32][32] = '{default: 0};
    logic [31:0] mem_tb  [256][8] = '{default: '0};
    logic [31:0] mem_exp [256][8] = '{default: '0};
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // VRF: an element reads as pending until it has been read pend_base times in total.
    always @(posedge clk) begin
        logic [LANES*(DATA_W+1)-1:0] tmp;
        int e;
        for (int l = 0; l < LANES; l++) begin
            if (vrf_rd_en) begin
                e = int'(vrf_rd_beat) * LANES + l;
                tmp[l*33 +: 33] = {rdcnt[vrf_rd_reg][e] < pend_base[vrf_rd_reg][e], vdata[vrf_rd_reg][e]};
                rdcnt[vrf_rd_reg][e] = rdcnt[vrf_rd_reg][e] + 1;
            end else begin
                tmp[l*33 +: 33] = {1'($urandom_range(0, 1)), 32'($urandom)};
            end
        end
        vrf_rd_data <= tmp;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (req_valid && req_ready) aq.push_back(cyc);
            if (mem_we) begin
                wq.push_back('{cyc, mem_row, mem_lane_en});
                for (int l = 0; l < LANES; l++)
                    if (mem_lane_en[l]) mem_tb[mem_row][l] = mem_wdata[l*32 +: 32];
            end
            if (done_valid) dq.push_back('{cyc, done_tag});
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Each present beat costs READ+CHECK+WRITE plus two cycles per pending retry.
    function automatic exp_t model(input logic [4:0] v, input logic [31:0] a,
                                   input logic [31:0] m, input int nlim);
        exp_t e;
        int t;
        int r;
        int p;
        logic [7:0] row;
        t = 0;
        e.n = 0;
        for (int b = 0; b < 4; b++) begin
            if (m[b*8 +: 8] != 8'h00) begin
                r = 0;
                for (int l = 0; l < 8; l++) begin
                    p = pend_base[v][b*8+l] - rdcnt[v][b*8+l];
                    if (m[b*8+l] && p > r) r = p;
                end
                t = t + 3 + 2 * r;
                if (e.n < nlim) begin
                    row = a[b*8 +: 8];
                    e.wrel[e.n] = t;
                    e.row[e.n]  = row;
                    e.len[e.n]  = m[b*8 +: 8];
                    for (int l = 0; l < 8; l++)
                        if (m[b*8+l]) mem_exp[row][l] = vdata[v][b*8+l];
                    e.n++;
                end
            end
        end
        e.drel = t + 1;
        return e;
    endfunction

    task automatic prep_vreg(input logic [4:0] v, input bit with_pend);
        for (int e = 0; e < 32; e++) begin
            vdata[v][e] = $urandom;
            pend_base[v][e] = rdcnt[v][e] +
                ((with_pend && $urandom_range(0, 15) == 0) ? int'($urandom_range(1, 3)) : 0);
        end
    endtask

    task automatic set_req(input logic [3:0] t, input logic [4:0] v, input logic [31:0] a);
        req_tag = t;
        req_vreg = v;
        req_lsq_addr = a;
    endtask

    task automatic clear_q();
        wq.delete();
        dq.delete();
        aq.delete();
    endtask

    task automatic wait_accept(input int n);
        for (int k = 0; k < 60 && aq.size() < n; k++) tick();
        check_eq("accept", 64'(aq.size() >= n), 1);
    endtask

    task automatic wait_done(input int n, input int budget);
        for (int k = 0; k < budget && dq.size() < n; k++) tick();
        repeat (3) tick();
    endtask

    task automatic verify(input exp_t e, input int acc, input int wbase, input int didx, input logic [3:0] t);
        for (int i = 0; i < e.n; i++) begin
            if (wbase + i < wq.size()) begin
                check_eq("wr_cycle", wq[wbase+i].cyc - acc, e.wrel[i]);
                check_eq("wr_row", wq[wbase+i].row, e.row[i]);
                check_eq("wr_lane_en", wq[wbase+i].len, e.len[i]);
            end else begin
                check_eq("wr_missing", wq.size(), wbase + i + 1);
            end
        end
        if (didx < dq.size()) begin
            check_eq("done_cycle", dq[didx].cyc - acc, e.drel);
            check_eq("done_tag", dq[didx].tag, t);
        end else begin
            check_eq("done_missing", dq.size(), didx + 1);
        end
    endtask

    task automatic compare_rows(input logic [31:0] a);
        for (int b = 0; b < 4; b++)
            for (int l = 0; l < 8; l++)
                check_eq("mem", mem_tb[a[b*8 +: 8]][l], mem_exp[a[b*8 +: 8]][l]);
    endtask

    task automatic check_reset();
        check_eq("rst_req_ready", req_ready, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_rd_en", vrf_rd_en, 0);
        check_eq("rst_mem_we", mem_we, 0);
        check_eq("rst_done_valid", done_valid, 0);
        check_eq("rst_rd_reg", vrf_rd_reg, 0);
        check_eq("rst_rd_beat", vrf_rd_beat, 0);
        check_eq("rst_mem_row", mem_row, 0);
        check_eq("rst_wdata_zero", 64'(mem_wdata == '0), 1);
        check_eq("rst_lane_en", mem_lane_en, 0);
        check_eq("rst_done_tag", done_tag, 0);
    endtask

    task automatic run_one(input logic [3:0] t, input logic [4:0] v, input logic [31:0] a,
                           input logic [31:0] m, output int acc, output exp_t e);
        clear_q();
        e = model(v, a, m, 4);
        set_req(t, v, a);
`ifdef STORE_MASK_EN
        req_mask = m;
`endif
        req_valid = 1'b1;
        wait_accept(1);
        req_valid = 1'b0;
        acc = (aq.size() > 0) ? aq[0] : 0;
        wait_done(1, e.drel + 20);
        verify(e, acc, 0, 0, t);
        check_eq("n_writes", wq.size(), e.n);
        check_eq("n_done", dq.size(), 1);
        compare_rows(a);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e, eb;
        int acc;
        logic [31:0] a, m;
        logic [4:0] v;

        repeat (3) tick();
        check_reset();
        rst = 1'b0;
        tick();

        // Plain store, element e = 100+e
        for (int i = 0; i < 32; i++) begin
            vdata[3][i] = 32'(100 + i);
            pend_base[3][i] = rdcnt[3][i];
        end
        run_one(4'hA, 5'd3, 32'h1312_1110, '1, acc, e);
        if (dq.size() > 0) check_eq("t1_done_at_13", dq[0].cyc - acc, 13);
        check_eq("row11_lane0", mem_tb[8'h11][0], 108);

        // Beat 1 lane 5 pending for two reads
        prep_vreg(5'd3, 1'b0);
        pend_base[3][13] = rdcnt[3][13] + 2;
        run_one(4'h3, 5'd3, 32'h2322_2120, '1, acc, e);
        if (dq.size() > 0) check_eq("pend_done_at_17", dq[0].cyc - acc, 17);
        if (wq.size() > 1) check_eq("pend_beat1_wr_at_10", wq[1].cyc - acc, 10);

        // Reset during beat 2 CHECK
        prep_vreg(5'd5, 1'b0);
        clear_q();
        e = model(5'd5, 32'h3332_3130, '1, 2);
        set_req(4'h6, 5'd5, 32'h3332_3130);
`ifdef STORE_MASK_EN
        req_mask = '1;
`endif
        req_valid = 1'b1;
        wait_accept(1);
        req_valid = 1'b0;
        acc = (aq.size() > 0) ? aq[0] : cyc;
        for (int k = 0; k < 40 && cyc < acc + 8; k++) tick();
        check_eq("pre_rst_beat", vrf_rd_beat, 2);
        check_eq("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        check_reset();
        tick();
        tick();
        rst = 1'b0;
        repeat (20) tick();
        check_eq("abort_n_writes", wq.size(), 2);
        check_eq("abort_n_done", dq.size(), 0);
        compare_rows(32'h3332_3130);
        prep_vreg(5'd6, 1'b1);
        run_one(4'h7, 5'd6, 32'h3736_3534, '1, acc, e);

        // req_valid held across an active store
        prep_vreg(5'd7, 1'b0);
        prep_vreg(5'd8, 1'b0);
        clear_q();
        e  = model(5'd7, 32'h4342_4140, '1, 4);
        eb = model(5'd8, 32'h5352_5150, '1, 4);
        set_req(4'h5, 5'd7, 32'h4342_4140);
`ifdef STORE_MASK_EN
        req_mask = '1;
`endif
        req_valid = 1'b1;
        wait_accept(1);
        set_req(4'h9, 5'd8, 32'h5352_5150);
        wait_accept(2);
        req_valid = 1'b0;
        wait_done(2, 60);
        if (aq.size() > 1) begin
            check_eq("held_accept_gap", aq[1] - aq[0], 14);
            verify(e, aq[0], 0, 0, 4'h5);
            verify(eb, aq[1], e.n, 1, 4'h9);
            if (wq.size() > 4) check_eq("second_first_we", wq[4].cyc - aq[1], 3);
        end
        check_eq("held_n_writes", wq.size(), 8);
        compare_rows(32'h4342_4140);
        compare_rows(32'h5352_5150);

`ifdef STORE_MASK_EN
        prep_vreg(5'd9, 1'b0);
        run_one(4'h2, 5'd9, 32'h6362_6160, 32'h0000_FF0F, acc, e);
        if (wq.size() > 1) begin
            check_eq("mask_b0_len", wq[0].len, 8'h0F);
            check_eq("mask_b1_len", wq[1].len, 8'hFF);
        end
        if (dq.size() > 0) check_eq("mask_done_at_7", dq[0].cyc - acc, 7);
        run_one(4'h4, 5'd9, 32'h6766_6564, 32'h0, acc, e);
        check_eq("mask0_no_we", wq.size(), 0);
        if (dq.size() > 0) check_eq("mask0_done_at_1", dq[0].cyc - acc, 1);
`endif

        // Randomized stores with occasional pending elements
        for (int k = 0; k < 20; k++) begin
            v = 5'($urandom_range(0, 31));
            a = $urandom;
            m = '1;
`ifdef STORE_MASK_EN
            for (int b = 0; b < 4; b++) begin
                case ($urandom_range(0, 3))
                    0:       m[b*8 +: 8] = 8'h00;
                    1:       m[b*8 +: 8] = 8'hFF;
                    default: m[b*8 +: 8] = 8'($urandom_range(1, 255));
                endcase
            end
`endif
            prep_vreg(v, 1'b1);
            run_one(4'($urandom), v, a, m, acc, e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
